fetch_unit: RTL and testbench

//  Sequential successor to the combinational next-PC logic. Owns the PC register and the redirect priority.

---
 rtl/fetch_pkg.sv | 7 +
 rtl/fetch_fifo.sv | 49 ++++
 rtl/fetch_unit.sv | 149 ++++++++++++++
 tb/tb_fetch_unit.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and redirect-source encoding for the fetch unit.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0000;

  typedef enum logic [2:0] {EXCRET, EXC, JMP, BR, NONE} redirect_src_e;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count. A push while full is
// accepted only when a pop happens in the same cycle.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);
  assign head    = mem[rd_ptr];

  // Flush shares the reset path so a flushed entry can never reappear at the head.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: PC register, redirect priority, credit-limited imem requests and
// a {pc,inst} FIFO for decode. Define FETCH_PERF_EN to add performance counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] EXC_VEC  = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            eret,
  input  logic [XLEN-1:0] epc,
  input  logic            exception,
  input  logic            jmp,
  input  logic            branch,
  input  logic            taken,
  input  logic [XLEN-1:0] br_pc,
  input  logic [25:0]     target,
  input  logic [15:0]     imm,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            rsp_valid,
  input  logic [XLEN-1:0] rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_data,
  output logic            redirect
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_dropped,
  output logic [31:0]     perf_stall
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int DW = 16;

  redirect_src_e src;
  logic          redirect_in;
  logic [29:0]   pc_w;
  logic [29:0]   next_pc_w;
  logic [29:0]   tag_head;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] tag_count;
  logic [DW-1:0] discard;
  logic [63:0]   fifo_head;
  logic          accept;
  logic          rsp_live;
  logic          rsp_drop;
  logic          push_live;
  logic          unused_low;

  assign unused_low = ^{epc[1:0], br_pc[1:0]};

  always_comb begin
    src = NONE;
    if (eret)                 src = EXCRET;
    else if (exception)       src = EXC;
    else if (jmp)             src = JMP;
    else if (branch && taken) src = BR;
  end

  // All PC arithmetic is on word addresses, so wrap at 2^30 words is implicit.
  always_comb begin
    next_pc_w = pc_w;
    case (src)
      EXCRET:  next_pc_w = epc[31:2];
      EXC:     next_pc_w = EXC_VEC[31:2];
      JMP:     next_pc_w = {br_pc[31:28], target};
      BR:      next_pc_w = br_pc[31:2] + 30'd1 + {{14{imm[15]}}, imm};
      default: next_pc_w = pc_w;
    endcase
  end

  assign redirect_in = (src != NONE);
  assign req_valid   = !rst && !redirect_in &&
                       (({1'b0, fifo_count} + {1'b0, tag_count}) < (CW+1)'(DEPTH));
  assign req_addr    = {pc_w, 2'b00};
  assign accept      = req_valid && req_ready;

  // The tag queue holds only live requests, so its occupancy is the outstanding count.
  assign rsp_drop  = rsp_valid && (discard != '0);
  assign rsp_live  = rsp_valid && (discard == '0);
  assign push_live = rsp_live && !redirect_in;

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(30)) u_tag_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_in),
    .push      (accept),
    .push_data (pc_w),
    .pop       (rsp_live),
    .head      (tag_head),
    .count     (tag_count)
  );

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(64)) u_data_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_in),
    .push      (push_live),
    .push_data ({tag_head, 2'b00, rsp_data}),
    .pop       (inst_ready),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign inst_valid = (fifo_count != '0);
  assign inst_pc    = fifo_head[63:32];
  assign inst_data  = fifo_head[31:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_w     <= RESET_PC[31:2];
      redirect <= 1'b0;
    end else begin
      redirect <= redirect_in;
      if (redirect_in)  pc_w <= next_pc_w;
      else if (accept)  pc_w <= pc_w + 30'd1;
    end
  end

  // On redirect every still-outstanding old-path response becomes a future drop.
  always_ff @(posedge clk) begin
    if (rst)              discard <= '0;
    else if (redirect_in) discard <= discard - DW'(rsp_drop) + DW'(tag_count) - DW'(rsp_live);
    else if (rsp_drop)    discard <= discard - DW'(1);
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
      perf_stall   <= '0;
    end else begin
      if (push_live && (perf_fetched != '1))
        perf_fetched <= perf_fetched + 32'd1;
      if (rsp_valid && !push_live && (perf_dropped != '1))
        perf_dropped <= perf_dropped + 32'd1;
      if (inst_ready && !inst_valid && (perf_stall != '1))
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit with an in-bench imem model.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        eret, exception, jmp, branch, taken;
  logic [31:0] epc, br_pc;
  logic [25:0] target;
  logic [15:0] imm;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_pc, inst_data;
  logic        redirect;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_dropped, perf_stall;
`endif

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .EXC_VEC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .eret       (eret),
    .epc        (epc),
    .exception  (exception),
    .jmp        (jmp),
    .branch     (branch),
    .taken      (taken),
    .br_pc      (br_pc),
    .target     (target),
    .imm        (imm),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_pc    (inst_pc),
    .inst_data  (inst_data),
    .redirect   (redirect)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_dropped (perf_dropped),
    .perf_stall   (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] pc; logic [31:0] inst;} item_t;
  typedef struct {int due; logic [31:0] addr;} mreq_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          imem_lat = 1;
  logic        rst_q;
  logic        exp_redirect = 1'b0;
  logic [31:0] model_pc = RESET_PC;
  logic        redir_now;
  item_t       exp_q[$];
  mreq_t       mem_q[$];

  assign redir_now = eret | exception | jmp | (branch & taken);

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'hA5A5_0F0F;
  endfunction

  // Redirect target straight from the architectural rules, in byte addresses.
  function automatic logic [31:0] model_target();
    logic [31:0] t;
    if (eret)           t = epc & 32'hFFFF_FFFC;
    else if (exception) t = 32'h0000_0000;
    else if (jmp)       t = {br_pc[31:28], target, 2'b00};
    else                t = (br_pc + 32'd4 + 32'(int'($signed(imm)) * 4)) & 32'hFFFF_FFFC;
    return t;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic rr, input logic ir, input logic [4:0] rd,
                                input logic [31:0] e_pc, input logic [31:0] b_pc,
                                input logic [25:0] tgt, input logic [15:0] im);
    @(negedge clk);
    req_ready  = rr;
    inst_ready = ir;
    {eret, exception, jmp, branch, taken} = rd;
    epc    = e_pc;
    br_pc  = b_pc;
    target = tgt;
    imm    = im;
  endtask

  task automatic idle(input logic rr, input logic ir);
    apply_stimulus(rr, ir, 5'b0, $urandom, $urandom, 26'($urandom), 16'($urandom));
  endtask

  task automatic do_reset(input logic rr, input logic ir);
    idle(1'b0, 1'b0);
    rst = 1'b1;
    idle(1'b0, 1'b0);
    idle(rr, ir);
    rst = 1'b0;
  endtask

  task automatic run_random(input int n, input bit vary_lat);
    logic [4:0] rd;
    for (int i = 0; i < n; i++) begin
      rd = 5'b0;
      if ($urandom_range(99) < 6) rd = 5'($urandom_range(1, 31));
      if (vary_lat) imem_lat = $urandom_range(1, 4);
      apply_stimulus($urandom_range(99) < 75, $urandom_range(99) < 70, rd,
                     $urandom, $urandom, 26'($urandom), 16'($urandom));
    end
  endtask

  // imem model: in-order responses, one per cycle, at least imem_lat cycles after accept.
  initial begin : imem
    rsp_valid = 1'b0;
    rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        rsp_valid = 1'b1;
        rsp_data  = mem_word(mem_q[0].addr);
        mem_q.delete(0);
      end else begin
        rsp_valid = 1'b0;
        rsp_data  = '0;
      end
    end
  end

  // Stimulus-side model: every accepted request pushes its expected {pc,inst}.
  initial begin : model
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        exp_q.delete();
        mem_q.delete();
        model_pc     = RESET_PC;
        exp_redirect = 1'b0;
      end else if (redir_now) begin
        exp_q.delete();
        model_pc     = model_target();
        exp_redirect = 1'b1;
      end else begin
        exp_redirect = 1'b0;
        if (req_valid && req_ready) begin
          check_output("req_addr", req_addr, model_pc);
          exp_q.push_back('{model_pc, mem_word(model_pc)});
          mem_q.push_back('{cyc + imem_lat, req_addr});
          model_pc = model_pc + 32'd4;
        end
      end
    end
  end

  // Monitor: credit-limited req_valid, redirect pulse and in-order decode stream.
  initial begin : monitor
    item_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_q === 1'b1) begin
        check_output("rst_inst_valid", 32'(inst_valid), 32'd0);
        check_output("rst_redirect", 32'(redirect), 32'd0);
      end
      if (rst === 1'b1) begin
        check_output("rst_req_valid", 32'(req_valid), 32'd0);
      end else if (rst_q !== 1'bx) begin
        check_output("req_valid", 32'(req_valid), 32'(!redir_now && exp_q.size() < DEPTH));
        check_output("redirect_pulse", 32'(redirect), 32'(exp_redirect));
        if (inst_valid && inst_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_inst cycle=%0d actual pc=%h expected none", cyc, inst_pc);
          end else begin
            e = exp_q.pop_front();
            check_output("inst_pc", inst_pc, e.pc);
            check_output("inst_data", inst_data, e.inst);
          end
        end
      end
    end
  end

  initial begin : driver
    int  first;
    int  n;
    bit  wrapped;
    rst = 1'b1;
    {eret, exception, jmp, branch, taken} = 5'b0;
    epc = '0; br_pc = '0; target = '0; imm = '0;
    req_ready = 1'b0; inst_ready = 1'b0;

    // Straight-line fetch from reset, 1-cycle imem.
    do_reset(1'b1, 1'b1);
    first = -1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (inst_valid && first < 0) first = i;
      idle(1'b1, 1'b1);
    end
    check_output("first_inst_valid_cycle", 32'(first), 32'd2);

    // Decode stalled: exactly DEPTH requests, then one more after a single pop.
    do_reset(1'b1, 1'b0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (req_valid && req_ready) n++;
      idle(1'b1, 1'b0);
    end
    check_output("stall_requests", 32'(n), 32'(DEPTH));
    idle(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      #1;
      if (req_valid && req_ready) n++;
      idle(1'b1, 1'b0);
    end
    check_output("requests_after_pop", 32'(n), 32'(DEPTH + 1));

    // Taken branch with in-flight responses on a 3-cycle imem.
    imem_lat = 3;
    repeat (6) idle(1'b1, 1'b1);
    apply_stimulus(1'b1, 1'b1, 5'b00011, $urandom, 32'h0000_0100, 26'($urandom), 16'hFFFF);
    idle(1'b1, 1'b1);
    #1;
    check_output("branch_req_addr", req_addr, 32'h0000_0100);
    check_output("branch_req_valid", 32'(req_valid), 32'd1);
    repeat (8) idle(1'b1, 1'b1);

    // eret beats exception and jmp; redirect is a one-cycle pulse.
    apply_stimulus(1'b1, 1'b1, 5'b11100, 32'h0000_0040, 32'h1234_5678, 26'h3FF_FFFF, 16'h0);
    idle(1'b1, 1'b1);
    #1;
    check_output("eret_req_addr", req_addr, 32'h0000_0040);
    check_output("eret_redirect_hi", 32'(redirect), 32'd1);
    idle(1'b1, 1'b1);
    #1;
    check_output("eret_redirect_lo", 32'(redirect), 32'd0);
    repeat (4) idle(1'b1, 1'b1);

    // Jump target concatenation, then PC wrap at the top of the address space.
    apply_stimulus(1'b1, 1'b1, 5'b00100, $urandom, 32'hA000_0010, 26'h000_0001, 16'h0);
    idle(1'b1, 1'b1);
    #1;
    check_output("jmp_req_addr", req_addr, 32'hA000_0004);
    apply_stimulus(1'b1, 1'b1, 5'b10000, 32'hFFFF_FFF8, $urandom, 26'($urandom), 16'($urandom));
    wrapped = 1'b0;
    for (int i = 0; i < 10; i++) begin
      idle(1'b1, 1'b1);
      #1;
      if (req_valid && req_ready && req_addr == 32'h0000_0000) wrapped = 1'b1;
    end
    check_output("pc_wrap_seen", 32'(wrapped), 32'd1);

    // Random traffic and redirects, then a mid-run reset and varying latency.
    run_random(800, 1'b0);
    do_reset(1'b1, 1'b1);
    run_random(400, 1'b1);

    // Drain: every accepted current-path request must reach decode.
    imem_lat = 1;
    repeat (30) idle(1'b0, 1'b1);
    #3;
    check_output("drain_leftover", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
